mem_access_stage: RTL and testbench
===================================

# mem_access_stage

Memory-access stage of the 32-bit pipeline. It sits directly downstream of the EX/MEM pipeline register and consumes its RD2, ALU result, control bits and destination register. It performs loads and stores over a req/ack data-memory bus, stalling the upstream pipeline while a transfer is outstanding. It presents a registered write-back bundle to the MEM/WB side.

## Interface
- N, 32, datapath and address width
- MAX_WAIT, 15, WAIT cycles without ack before a transfer is aborted (1..255)

- CLK  in  1  clock; all state updates on posedge CLK
- RST  in  1  reset, synchronous, active-high
- RD2_i  in  N  store data
- AluResult_i  in  N  effective address (memory op) or ALU result (non-memory op)
- RF_WE_i  in  1  register-file write enable
- MemWE_i  in  1  store request
- WBSelect_i  in  1  1 = load (write-back from memory), 0 = write-back from ALU
- A3_i  in  4  destination register
- stall_o  out  1  combinational; upstream stages hold while high
- mem_req_o  out  1  bus request, registered
- mem_we_o  out  1  1 = write, registered
- mem_addr_o  out  N  bus address, registered
- mem_wdata_o  out  N  bus write data, registered
- mem_ack_i  in  1  bus completion; read data valid in the same cycle
- mem_rdata_i  in  N  read data
- WBData_o  out  N  write-back data
- A3_o  out  4  write-back register
- RF_WE_o  out  1  write-back enable
- err_o  out  1  one-cycle pulse on bus timeout
- misalign_o  out  1  one-cycle pulse on a misaligned access (see Configuration)

## Operation
- Memory op: memop = MemWE_i | WBSelect_i.
- States: IDLE, WAIT.
- **IDLE, no memop**
  - Next edge: WBData_o←AluResult_i, A3_o←A3_i, RF_WE_o←RF_WE_i.
  - Stay in IDLE.
- **IDLE, memop**
  - Next edge: mem_req_o←1, mem_we_o←MemWE_i, mem_addr_o←AluResult_i, mem_wdata_o←RD2_i.
  - Also latch A3_i, RF_WE_i, WBSelect_i internally; clear the wait counter; RF_WE_o←0 (bubble); go to WAIT.
- **WAIT, no ack**
  - Hold all bus outputs stable; counter increments; RF_WE_o←0.
- **WAIT, mem_ack_i=1**
  - Next edge: mem_req_o←0.
  - WBData_o←latched WBSelect ? mem_rdata_i : mem_addr_o.
  - A3_o←latched A3; RF_WE_o←latched RF_WE; go to IDLE.
- **WAIT, counter reaches MAX_WAIT with no ack**
  - Next edge: mem_req_o←0, err_o←1 for one cycle, RF_WE_o←0 (write-back suppressed), go to IDLE.
  - An ack arriving in that same cycle takes priority over the timeout: normal completion, no error.
- stall_o = (IDLE & memop) | (WAIT & ~mem_ack_i & ~timeout). It drops in the completion or abort cycle, so upstream advances on that same edge.
- Store with RF_WE_i=1 is legal: write-back uses the address value.
- Back-to-back memory ops: each op costs at least 2 cycles (IDLE sample + WAIT ack).

## Timing
- Reset (RST high at an edge) sets:
  - state IDLE, counter 0
  - mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o = 0
  - WBData_o=0, A3_o=0, RF_WE_o=0, err_o=0, misalign_o=0
- Reset mid-transfer drops mem_req_o at that edge with no write-back and no error; the bus must tolerate an abandoned request.
- Non-memory latency: 1 cycle, input to WB outputs.
- Memory latency: 1 + k cycles, where k is the WAIT cycle in which ack arrives (k ≥ 1, minimum 2).
- mem_ack_i outside WAIT is ignored.

## Configuration
- MEM_ALIGN_CHECK_EN defined:
  - A memop with AluResult_i[1:0]≠0 in IDLE issues no request and raises no stall.
  - Next edge: misalign_o←1 for one cycle, RF_WE_o←0; state stays IDLE.
- MEM_ALIGN_CHECK_EN undefined:
  - mem_addr_o[1:0] is forced to 0 (word-aligned truncation).
  - misalign_o is tied 0.

## Structure
- Package mem_stage_pkg holds the state enum (IDLE, WAIT) and the default MAX_WAIT constant.
- Sub-module mem_wait_timer holds the wait counter:
  - inputs clear and enable; output expired
  - width $clog2(MAX_WAIT+1)

## Test plan
- **Reset mid-transfer:** RST during WAIT → next cycle mem_req_o=0, all outputs 0, state IDLE.
- **ALU passthrough:** AluResult_i=0x0000_1234, A3_i=5, RF_WE_i=1, no memop → one cycle later WBData_o=0x1234, A3_o=5, RF_WE_o=1; stall_o never high.
- **Load, ack after 3 WAIT cycles:** AluResult_i=0x100, WBSelect_i=1, A3_i=2, rdata=0xDEAD_BEEF on ack →
  - mem_addr_o=0x100, mem_we_o=0
  - stall_o high for 4 cycles
  - WBData_o=0xDEADBEEF, A3_o=2, RF_WE_o=1 the cycle after ack
- **Store, immediate ack:** MemWE_i=1, addr 0x200, RD2_i=0x55 →
  - mem_we_o=1, mem_wdata_o=0x55
  - 2-cycle op, RF_WE_o=0
- **Timeout, MAX_WAIT=4, no ack:**
  - err_o pulses once after 4 WAIT cycles
  - mem_req_o drops, RF_WE_o stays 0, stall_o releases
- **Misalignment:** load at 0x102 →
  - with MEM_ALIGN_CHECK_EN: misalign_o pulse, no mem_req_o, no stall
  - without: mem_addr_o=0x100

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory-access stage.
package mem_stage_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StWait
  } mem_state_e;

  localparam int unsigned MaxWaitDefault = 15;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts WAIT cycles without an ack; o_expired marks the last cycle allowed before abort.
module mem_wait_timer #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic CLK,
  input  logic RST,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int unsigned CntW = $clog2(MAX_WAIT + 1);

  logic [CntW-1:0] r_count;

  always_ff @(posedge CLK) begin
    if (RST || i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + CntW'(1);
    end
  end

  // The count excludes the current cycle, so MAX_WAIT-1 means this is WAIT cycle number MAX_WAIT.
  assign o_expired = (r_count == CntW'(MAX_WAIT - 1));

endmodule

// File: rtl/mem_access_stage.sv
// Pipeline memory-access stage: req/ack data bus, upstream stall, registered write-back.
// Optional MEM_ALIGN_CHECK_EN rejects misaligned accesses instead of truncating the address.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned N        = 32,
  parameter int unsigned MAX_WAIT = MaxWaitDefault
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [N-1:0] RD2_i,
  input  logic [N-1:0] AluResult_i,
  input  logic         RF_WE_i,
  input  logic         MemWE_i,
  input  logic         WBSelect_i,
  input  logic [3:0]   A3_i,
  output logic         stall_o,
  output logic         mem_req_o,
  output logic         mem_we_o,
  output logic [N-1:0] mem_addr_o,
  output logic [N-1:0] mem_wdata_o,
  input  logic         mem_ack_i,
  input  logic [N-1:0] mem_rdata_i,
  output logic [N-1:0] WBData_o,
  output logic [3:0]   A3_o,
  output logic         RF_WE_o,
  output logic         err_o,
  output logic         misalign_o
);

  mem_state_e  r_state;
  logic [3:0]  r_a3;
  logic        r_rf_we;
  logic        r_wbsel;

  logic         w_memop;
  logic         w_misalign;
  logic [N-1:0] w_addr;
  logic         w_idle;
  logic         w_wait;
  logic         w_issue;
  logic         w_expired;

  assign w_memop = MemWE_i | WBSelect_i;
  assign w_idle  = (r_state == StIdle);
  assign w_wait  = (r_state == StWait);

`ifdef MEM_ALIGN_CHECK_EN
  assign w_misalign = w_memop & (|AluResult_i[1:0]);
  assign w_addr     = AluResult_i;
`else
  assign w_misalign = 1'b0;
  assign w_addr     = {AluResult_i[N-1:2], 2'b00};
`endif

  assign w_issue = w_idle & w_memop & ~w_misalign;
  assign stall_o = w_issue | (w_wait & ~mem_ack_i & ~w_expired);

  mem_wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_timer (
    .CLK       (CLK),
    .RST       (RST),
    .i_clear   (w_idle),
    .i_enable  (w_wait & ~mem_ack_i),
    .o_expired (w_expired)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= StIdle;
      r_a3        <= '0;
      r_rf_we     <= 1'b0;
      r_wbsel     <= 1'b0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      WBData_o    <= '0;
      A3_o        <= '0;
      RF_WE_o     <= 1'b0;
      err_o       <= 1'b0;
      misalign_o  <= 1'b0;
    end else begin
      err_o      <= 1'b0;
      misalign_o <= 1'b0;
      case (r_state)
        StIdle: begin
          if (w_issue) begin
            mem_req_o   <= 1'b1;
            mem_we_o    <= MemWE_i;
            mem_addr_o  <= w_addr;
            mem_wdata_o <= RD2_i;
            r_a3        <= A3_i;
            r_rf_we     <= RF_WE_i;
            r_wbsel     <= WBSelect_i;
            RF_WE_o     <= 1'b0;
            r_state     <= StWait;
          end else if (w_misalign) begin
            misalign_o <= 1'b1;
            RF_WE_o    <= 1'b0;
          end else begin
            WBData_o <= AluResult_i;
            A3_o     <= A3_i;
            RF_WE_o  <= RF_WE_i;
          end
        end
        StWait: begin
          // Ack wins over a timeout landing in the same cycle.
          if (mem_ack_i) begin
            mem_req_o <= 1'b0;
            WBData_o  <= r_wbsel ? mem_rdata_i : mem_addr_o;
            A3_o      <= r_a3;
            RF_WE_o   <= r_rf_we;
            r_state   <= StIdle;
          end else if (w_expired) begin
            mem_req_o <= 1'b0;
            err_o     <= 1'b1;
            RF_WE_o   <= 1'b0;
            r_state   <= StIdle;
          end else begin
            RF_WE_o <= 1'b0;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage with MAX_WAIT=4.
module tb_mem_access_stage;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] RD2_i;
  logic [31:0] AluResult_i;
  logic        RF_WE_i;
  logic        MemWE_i;
  logic        WBSelect_i;
  logic [3:0]  A3_i;
  logic        stall_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic [31:0] WBData_o;
  logic [3:0]  A3_o;
  logic        RF_WE_o;
  logic        err_o;
  logic        misalign_o;

  int n_total = 0;
  int n_bad   = 0;
  int stall_cnt;

  always #5 CLK = ~CLK;

  mem_access_stage #(
    .N        (32),
    .MAX_WAIT (4)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .RD2_i       (RD2_i),
    .AluResult_i (AluResult_i),
    .RF_WE_i     (RF_WE_i),
    .MemWE_i     (MemWE_i),
    .WBSelect_i  (WBSelect_i),
    .A3_i        (A3_i),
    .stall_o     (stall_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_ack_i   (mem_ack_i),
    .mem_rdata_i (mem_rdata_i),
    .WBData_o    (WBData_o),
    .A3_o        (A3_o),
    .RF_WE_o     (RF_WE_o),
    .err_o       (err_o),
    .misalign_o  (misalign_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic nop();
    RD2_i       = '0;
    AluResult_i = '0;
    RF_WE_i     = 1'b0;
    MemWE_i     = 1'b0;
    WBSelect_i  = 1'b0;
    A3_i        = '0;
  endtask

  initial begin
    nop();
    mem_ack_i   = 1'b0;
    mem_rdata_i = '0;
    RST         = 1'b1;
    tick();
    tick();
    chk("rst_req", mem_req_o, 0);
    chk("rst_we", mem_we_o, 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_wdata", mem_wdata_o, 0);
    chk("rst_wbdata", WBData_o, 0);
    chk("rst_a3", A3_o, 0);
    chk("rst_rfwe", RF_WE_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_mis", misalign_o, 0);
    RST = 1'b0;

    // ALU passthrough
    AluResult_i = 32'h0000_1234; A3_i = 4'd5; RF_WE_i = 1'b1;
    #1 chk("alu_stall", stall_o, 0);
    tick();
    chk("alu_wb", WBData_o, 32'h1234);
    chk("alu_a3", A3_o, 5);
    chk("alu_rfwe", RF_WE_o, 1);
    nop();

    // Load, ack in the 4th WAIT cycle (coincides with timeout: ack must win)
    AluResult_i = 32'h100; WBSelect_i = 1'b1; A3_i = 4'd2; RF_WE_i = 1'b1;
    stall_cnt = 0;
    #1 stall_cnt += int'(stall_o);
    tick();
    chk("ld_req", mem_req_o, 1);
    chk("ld_addr", mem_addr_o, 32'h100);
    chk("ld_we", mem_we_o, 0);
    chk("ld_bubble", RF_WE_o, 0);
    for (int k = 1; k <= 3; k++) begin
      #1 stall_cnt += int'(stall_o);
      tick();
    end
    nop();
    mem_ack_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
    #1 stall_cnt += int'(stall_o);
    chk("ld_stall_cycles", stall_cnt, 4);
    tick();
    mem_ack_i = 1'b0;
    chk("ld_wb", WBData_o, 32'hDEAD_BEEF);
    chk("ld_a3", A3_o, 2);
    chk("ld_rfwe", RF_WE_o, 1);
    chk("ld_req_drop", mem_req_o, 0);
    chk("ld_no_err", err_o, 0);

    // Store, immediate ack
    MemWE_i = 1'b1; AluResult_i = 32'h200; RD2_i = 32'h55; A3_i = 4'd7;
    #1 chk("st_stall0", stall_o, 1);
    tick();
    chk("st_req", mem_req_o, 1);
    chk("st_we", mem_we_o, 1);
    chk("st_addr", mem_addr_o, 32'h200);
    chk("st_wdata", mem_wdata_o, 32'h55);
    nop();
    mem_ack_i = 1'b1;
    #1 chk("st_stall1", stall_o, 0);
    tick();
    mem_ack_i = 1'b0;
    chk("st_req_drop", mem_req_o, 0);
    chk("st_rfwe", RF_WE_o, 0);
    chk("st_wb", WBData_o, 32'h200);

    // Timeout: no ack for MAX_WAIT=4 cycles
    AluResult_i = 32'h300; WBSelect_i = 1'b1; A3_i = 4'd3; RF_WE_i = 1'b1;
    tick();
    nop();
    for (int k = 1; k <= 3; k++) begin
      #1 chk("to_stall", stall_o, 1);
      chk("to_err_early", err_o, 0);
      tick();
    end
    #1 chk("to_stall_rel", stall_o, 0);
    tick();
    chk("to_err", err_o, 1);
    chk("to_req", mem_req_o, 0);
    chk("to_rfwe", RF_WE_o, 0);
    tick();
    chk("to_err_pulse", err_o, 0);

    // Misaligned load at 0x102
    AluResult_i = 32'h102; WBSelect_i = 1'b1; A3_i = 4'd4; RF_WE_i = 1'b1;
`ifdef MEM_ALIGN_CHECK_EN
    #1 chk("mis_stall", stall_o, 0);
    tick();
    nop();
    chk("mis_pulse", misalign_o, 1);
    chk("mis_req", mem_req_o, 0);
    chk("mis_rfwe", RF_WE_o, 0);
    tick();
    chk("mis_pulse_end", misalign_o, 0);
`else
    #1 chk("mis_stall", stall_o, 1);
    tick();
    nop();
    chk("mis_addr", mem_addr_o, 32'h100);
    chk("mis_req", mem_req_o, 1);
    chk("mis_flag", misalign_o, 0);
    mem_ack_i = 1'b1; mem_rdata_i = 32'h1111_2222;
    tick();
    mem_ack_i = 1'b0;
    chk("mis_wb", WBData_o, 32'h1111_2222);
    chk("mis_rfwe", RF_WE_o, 1);
`endif

    // Reset in the middle of a transfer
    MemWE_i = 1'b1; AluResult_i = 32'h400; RD2_i = 32'h99; RF_WE_i = 1'b1; A3_i = 4'd9;
    tick();
    chk("rmid_req", mem_req_o, 1);
    nop();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("rmid_req_drop", mem_req_o, 0);
    chk("rmid_addr", mem_addr_o, 0);
    chk("rmid_rfwe", RF_WE_o, 0);
    chk("rmid_err", err_o, 0);
    chk("rmid_wb", WBData_o, 0);
    chk("rmid_stall", stall_o, 0);

    // Ack in IDLE is ignored: ALU op must pass through unchanged
    mem_ack_i = 1'b1; mem_rdata_i = 32'hBAD0_BAD0;
    AluResult_i = 32'h77; A3_i = 4'd1; RF_WE_i = 1'b1;
    tick();
    mem_ack_i = 1'b0;
    chk("idle_ack_wb", WBData_o, 32'h77);
    chk("idle_ack_req", mem_req_o, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
